// File: rtl/jtframe_z80_cenwait.sv
// jtframe_z80_cenwait
// Gates the Z80 clock enable while a ROM fetch from SDRAM is outstanding or a
// shared device is busy. Pulses lost while stalled are counted and, when
// RECOVERY is set, reissued afterwards so the average CPU speed is preserved.
module jtframe_z80_cenwait #(
    parameter int RECOVERY = 1,
    parameter int MISS_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cen_in,
    output logic              cen_out,
    output logic              gate,
    input  logic              mreq_n,
    input  logic              iorq_n,
    input  logic              busak_n,
    input  logic              dev_busy,
    input  logic              rom_cs,
    input  logic              rom_ok,
    output logic [MISS_W-1:0] miss_cnt
);

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_RECOVER = 2'd2;

    localparam logic [MISS_W-1:0] MISS_MAX = '1;
    localparam logic [MISS_W-1:0] MISS_ONE = MISS_W'(1);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              gate_nxt;
    logic [MISS_W-1:0] miss_nxt;
    logic [MISS_W-1:0] miss_inc;
    logic              cs_dly;
    logic              last_out;
    logic              stall;
    logic              extra;
    logic              cen_mux;

    // rom_ok is stale on the first clock of a new rom_cs, so it only counts
    // once rom_cs has been seen for a full clock; bus grant disables stalling
    assign stall = busak_n & ((rom_cs & ~mreq_n & ~(rom_ok & cs_dly)) |
                              (dev_busy & (~mreq_n | ~iorq_n)));

    // a lost pulse at the top of the counter range is simply dropped
    assign miss_inc = (miss_cnt == MISS_MAX) ? miss_cnt : miss_cnt + MISS_ONE;

    // recovery pulses fill idle slots only, never back to back with the last
    // output, and are held back while the bus is granted so the count survives
    assign extra = (state == ST_RECOVER) & ~cen_in & ~last_out &
                   (miss_cnt != '0) & ~stall & busak_n;

    // next-state, gate, counter and output-enable selection
    always_comb begin
        state_nxt = state;
        gate_nxt  = gate;
        miss_nxt  = miss_cnt;
        cen_mux   = 1'b0;
        case (state)
            ST_RUN: begin
                cen_mux = cen_in & ~stall;
                if (cen_in & stall) begin
                    gate_nxt  = 1'b0;
                    state_nxt = ST_WAIT;
                    miss_nxt  = miss_inc;
                end
            end
            ST_WAIT: begin
                if (cen_in) begin
                    miss_nxt = miss_inc;
                end
                if (!stall) begin
                    gate_nxt  = 1'b1;
                    state_nxt = (RECOVERY != 0 && miss_nxt != '0) ? ST_RECOVER : ST_RUN;
                end
            end
            ST_RECOVER: begin
                cen_mux = (cen_in & ~stall) | extra;
                if (cen_in & stall) begin
                    gate_nxt  = 1'b0;
                    state_nxt = ST_WAIT;
                    miss_nxt  = miss_inc;
                end else if (extra) begin
                    miss_nxt = miss_cnt - MISS_ONE;
                    if (miss_nxt == '0) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (RECOVERY == 0) begin
            miss_nxt = '0;
        end
    end

    // nothing reaches the CPU while reset is held
    assign cen_out = cen_mux & ~rst;

    // state registers, delayed rom_cs and the previous output pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            gate     <= 1'b1;
            miss_cnt <= '0;
            cs_dly   <= 1'b0;
            last_out <= 1'b0;
        end else begin
            state    <= state_nxt;
            gate     <= gate_nxt;
            miss_cnt <= miss_nxt;
            cs_dly   <= rom_cs;
            last_out <= cen_out;
        end
    end

endmodule

// File: tb/tb_jtframe_z80_cenwait.sv
// tb_jtframe_z80_cenwait
// Three instances share one set of inputs: A (RECOVERY=1, MISS_W=4),
// B (RECOVERY=0) and C (MISS_W=2). Only the instance under test is out of
// reset; the others stay silent. Expected pulse cycles and gate/miss_cnt
// values are queued as stimulus is issued and popped by a negedge monitor.
module tb_jtframe_z80_cenwait;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic cen_in, mreq_n, iorq_n, busak_n, dev_busy, rom_cs, rom_ok;
    logic out_a, out_b, out_c;
    logic gate_a, gate_b, gate_c;
    logic [3:0] miss_a, miss_b;
    logic [1:0] miss_c;

    jtframe_z80_cenwait #(.RECOVERY(1), .MISS_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .cen_in(cen_in), .cen_out(out_a), .gate(gate_a),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .dev_busy(dev_busy),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .miss_cnt(miss_a));

    jtframe_z80_cenwait #(.RECOVERY(0), .MISS_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .cen_in(cen_in), .cen_out(out_b), .gate(gate_b),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .dev_busy(dev_busy),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .miss_cnt(miss_b));

    jtframe_z80_cenwait #(.RECOVERY(1), .MISS_W(2)) dut_c (
        .clk(clk), .rst(rst_c), .cen_in(cen_in), .cen_out(out_c), .gate(gate_c),
        .mreq_n(mreq_n), .iorq_n(iorq_n), .busak_n(busak_n), .dev_busy(dev_busy),
        .rom_cs(rom_cs), .rom_ok(rom_ok), .miss_cnt(miss_c));

    typedef struct {
        int    cyc;
        int    inst;
        logic  gate;
        int    miss;
        string name;
    } chk_t;

    typedef struct {
        int cyc;
        int inst;
    } pulse_t;

    chk_t   chk_q[$];
    pulse_t pulse_q[$];

    int   cyc = 0;
    logic cen_en = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   t;

    chk_t       mon_e;
    logic [2:0] exp_mask;
    logic [2:0] act_mask;
    logic       mon_gate;
    logic [3:0] mon_miss;

    // cycle index: inputs set #1 after posedge N belong to cycle N
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic push_chk(input int c, input int inst, input logic g,
                            input int m, input string name);
        chk_t e;
        e.cyc  = c;
        e.inst = inst;
        e.gate = g;
        e.miss = m;
        e.name = name;
        chk_q.push_back(e);
    endtask

    task automatic push_pulse(input int c, input int inst);
        pulse_t p;
        p.cyc  = c;
        p.inst = inst;
        pulse_q.push_back(p);
    endtask

    // advance one clock; cen_in is a one-clock pulse every 4th cycle
    task automatic apply_stimulus();
        @(posedge clk);
        #1;
        cen_in = cen_en && (cyc % 4 == 0);
    endtask

    task automatic run_until(input int target);
        while (cyc < target) apply_stimulus();
    endtask

    task automatic goto_phase0();
        do apply_stimulus(); while (cyc % 4 != 0);
    endtask

    task automatic idle_inputs();
        cen_en   = 1'b0;
        mreq_n   = 1'b1;
        iorq_n   = 1'b1;
        busak_n  = 1'b1;
        dev_busy = 1'b0;
        rom_cs   = 1'b0;
        rom_ok   = 1'b1;
    endtask

    // ROM stall sequence: rom_cs rises at t together with cen_in, then
    // rom_ok drops for 12 clocks covering cen_in at t+8, t+12, t+16
    task automatic rom_sequence(input int t0);
        rom_cs = 1'b1;
        run_until(t0 + 5);
        rom_ok = 1'b0;
        run_until(t0 + 17);
        rom_ok = 1'b1;
        run_until(t0 + 29);
        idle_inputs();
        run_until(t0 + 32);
    endtask

    // monitor: compares output pulses and queued state checks every cycle
    always @(negedge clk) begin
        exp_mask = 3'b000;
        while (pulse_q.size() > 0 && pulse_q[0].cyc == cyc) begin
            exp_mask[pulse_q[0].inst] = 1'b1;
            void'(pulse_q.pop_front());
        end
        act_mask = {out_c, out_b, out_a};
        if (exp_mask != 3'b000 || act_mask != 3'b000)
            check_output($sformatf("cen_out cycle %0d", cyc), 32'(act_mask), 32'(exp_mask));
        while (chk_q.size() > 0 && chk_q[0].cyc == cyc) begin
            mon_e = chk_q.pop_front();
            case (mon_e.inst)
                0:       begin mon_gate = gate_a; mon_miss = miss_a; end
                1:       begin mon_gate = gate_b; mon_miss = miss_b; end
                default: begin mon_gate = gate_c; mon_miss = {2'b00, miss_c}; end
            endcase
            check_output({mon_e.name, " gate"}, 32'(mon_gate), 32'(mon_e.gate));
            check_output({mon_e.name, " miss_cnt"}, 32'(mon_miss), mon_e.miss);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        cen_in = 1'b0;
        idle_inputs();
        repeat (3) apply_stimulus();

        // instance A: reset values, then first-clock rom_ok and 3-pulse stall
        rst_a = 1'b0;
        push_chk(cyc, 0, 1'b1, 0, "A reset");
        run_until(cyc + 2);
        mreq_n = 1'b0;
        rom_ok = 1'b1;
        cen_en = 1'b1;
        goto_phase0();
        t = cyc;
        push_chk(t + 1,  0, 1'b0, 1, "A stale rom_ok stall");
        push_chk(t + 2,  0, 1'b1, 1, "A stale rom_ok release");
        push_chk(t + 3,  0, 1'b1, 0, "A single recovery done");
        push_chk(t + 8,  0, 1'b1, 0, "A stall without cen_in");
        push_chk(t + 9,  0, 1'b0, 1, "A stall first miss");
        push_chk(t + 13, 0, 1'b0, 2, "A stall second miss");
        push_chk(t + 17, 0, 1'b0, 3, "A stall third miss");
        push_chk(t + 18, 0, 1'b1, 3, "A release");
        push_chk(t + 19, 0, 1'b1, 2, "A first extra");
        push_chk(t + 27, 0, 1'b1, 0, "A recovery done");
        push_pulse(t + 2, 0);
        push_pulse(t + 4, 0);
        for (int k = 18; k <= 28; k += 2) push_pulse(t + k, 0);
        rom_sequence(t);

        // instance B: same stimulus without recovery
        rst_a = 1'b1;
        rst_b = 1'b0;
        push_chk(cyc, 1, 1'b1, 0, "B reset");
        run_until(cyc + 2);
        mreq_n = 1'b0;
        rom_ok = 1'b1;
        cen_en = 1'b1;
        goto_phase0();
        t = cyc;
        push_chk(t + 1,  1, 1'b0, 0, "B stale rom_ok stall");
        push_chk(t + 2,  1, 1'b1, 0, "B stale rom_ok release");
        push_chk(t + 9,  1, 1'b0, 0, "B stall");
        push_chk(t + 17, 1, 1'b0, 0, "B stall held");
        push_chk(t + 18, 1, 1'b1, 0, "B release");
        push_pulse(t + 4,  1);
        push_pulse(t + 20, 1);
        push_pulse(t + 24, 1);
        push_pulse(t + 28, 1);
        rom_sequence(t);

        // instance C: 2-bit counter saturates over a 6-pulse stall
        rst_b = 1'b1;
        rst_c = 1'b0;
        push_chk(cyc, 2, 1'b1, 0, "C reset");
        rom_cs = 1'b1;
        mreq_n = 1'b0;
        rom_ok = 1'b1;
        run_until(cyc + 2);
        cen_en = 1'b1;
        goto_phase0();
        t = cyc;
        push_chk(t + 5,  2, 1'b0, 1, "C first miss");
        push_chk(t + 9,  2, 1'b0, 2, "C second miss");
        push_chk(t + 13, 2, 1'b0, 3, "C third miss");
        push_chk(t + 17, 2, 1'b0, 3, "C saturated");
        push_chk(t + 25, 2, 1'b0, 3, "C saturated held");
        push_chk(t + 26, 2, 1'b1, 3, "C release");
        push_chk(t + 27, 2, 1'b1, 2, "C first extra");
        push_chk(t + 35, 2, 1'b1, 0, "C recovery done");
        push_pulse(t, 2);
        for (int k = 26; k <= 36; k += 2) push_pulse(t + k, 2);
        run_until(t + 1);
        rom_ok = 1'b0;
        run_until(t + 25);
        rom_ok = 1'b1;
        run_until(t + 37);
        idle_inputs();
        run_until(t + 40);

        // instance A: dev_busy stall, bus grant mid-stall holds the count
        rst_c = 1'b1;
        rst_a = 1'b0;
        push_chk(cyc, 0, 1'b1, 0, "A reset again");
        run_until(cyc + 2);
        cen_en = 1'b1;
        goto_phase0();
        t = cyc;
        push_chk(t + 5,  0, 1'b0, 1, "A busy first miss");
        push_chk(t + 9,  0, 1'b0, 2, "A busy second miss");
        push_chk(t + 10, 0, 1'b0, 2, "A busak falls");
        push_chk(t + 11, 0, 1'b1, 2, "A busak gate");
        push_chk(t + 13, 0, 1'b1, 2, "A busak count held");
        push_chk(t + 15, 0, 1'b1, 1, "A busak released extra");
        push_chk(t + 19, 0, 1'b1, 0, "A busy recovery done");
        push_pulse(t, 0);
        for (int k = 12; k <= 20; k += 2) push_pulse(t + k, 0);
        run_until(t + 1);
        dev_busy = 1'b1;
        iorq_n   = 1'b0;
        run_until(t + 10);
        busak_n = 1'b0;
        run_until(t + 14);
        busak_n  = 1'b1;
        dev_busy = 1'b0;
        iorq_n   = 1'b1;
        run_until(t + 21);
        idle_inputs();
        run_until(t + 24);

        // instance A: reset while recovering with two pulses pending
        rom_cs = 1'b1;
        mreq_n = 1'b0;
        rom_ok = 1'b1;
        run_until(cyc + 2);
        cen_en = 1'b1;
        goto_phase0();
        t = cyc;
        push_chk(t + 5,  0, 1'b0, 1, "A pre-reset first miss");
        push_chk(t + 9,  0, 1'b0, 2, "A pre-reset second miss");
        push_chk(t + 10, 0, 1'b1, 2, "A recovering");
        push_chk(t + 11, 0, 1'b1, 0, "A after reset");
        push_chk(t + 14, 0, 1'b1, 0, "A no recovery after reset");
        push_pulse(t, 0);
        push_pulse(t + 12, 0);
        push_pulse(t + 16, 0);
        run_until(t + 1);
        rom_ok = 1'b0;
        run_until(t + 9);
        rom_ok = 1'b1;
        run_until(t + 10);
        rst_a = 1'b1;
        run_until(t + 11);
        rst_a = 1'b0;
        run_until(t + 17);
        idle_inputs();
        run_until(t + 24);

        check_output("leftover expectations", 32'(chk_q.size() + pulse_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
